// File: rtl/alu_seq_acc_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_acc_if
//  Brief    : Command / sample / result signal bundle for alu_seq_acc.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_acc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             overflow;
    logic             busy;

    modport master (
        output start, mode, din, din_valid, result_ready,
        input  din_ready, result, result_valid, overflow, busy
    );

    modport slave (
        input  start, mode, din, din_valid, result_ready,
        output din_ready, result, result_valid, overflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_acc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_acc
//  Brief    : Sequential reduction of NR_INPS samples (sum/min/max/xor).
//             Define ALU_SEQ_ACC_SAT_EN to make sum mode saturate.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq_acc #(
    parameter int WIDTH   = 32,
    parameter int NR_INPS = 4
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    alu_seq_acc_if.slave bus
);

    localparam int            CW        = $clog2(NR_INPS + 1);
    localparam logic [CW-1:0] C_LAST    = CW'(NR_INPS - 1);
    localparam logic [1:0]    C_MODE_SUM = 2'd0;
    localparam logic [1:0]    C_MODE_MIN = 2'd1;
    localparam logic [1:0]    C_MODE_MAX = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             din_ready_q, din_ready_d;
    logic             result_valid_q, result_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH:0]   sum_w;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_w   = {1'b0, acc_q} + {1'b0, bus.din};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                    mode_d  = bus.mode;
                end
            end
            CLEAR: begin
                // min needs the identity element all-ones, the others start at zero
                acc_d   = (mode_q == C_MODE_MIN) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                ovf_d   = 1'b0;
                cnt_d   = '0;
                state_d = ACCUM;
            end
            ACCUM: begin
                if (bus.din_valid && din_ready_q) begin
                    case (mode_q)
                        C_MODE_SUM: begin
`ifdef ALU_SEQ_ACC_SAT_EN
                            acc_d = sum_w[WIDTH] ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
`else
                            acc_d = sum_w[WIDTH-1:0];
`endif
                            ovf_d = ovf_q | sum_w[WIDTH];
                        end
                        C_MODE_MIN: acc_d = (bus.din < acc_q) ? bus.din : acc_q;
                        C_MODE_MAX: acc_d = (bus.din > acc_q) ? bus.din : acc_q;
                        default:    acc_d = acc_q ^ bus.din;
                    endcase
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == C_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Moore outputs are registered from the next state so they align with it
        din_ready_d    = (state_d == ACCUM);
        result_valid_d = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            mode_q         <= 2'd0;
            acc_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            din_ready_q    <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            din_ready_q    <= din_ready_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.din_ready    = din_ready_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result       = acc_q;
    assign bus.overflow     = ovf_q;
    assign bus.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_acc
//  Brief    : Directed scoreboard bench for alu_seq_acc (WIDTH=32, NR_INPS=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_acc;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_seq_acc_if #(.WIDTH(32)) bus ();

    alu_seq_acc #(
        .WIDTH   (32),
        .NR_INPS (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          errors    = 0;
    int          checks    = 0;
    int          cyc       = 0;
    int          start_cyc = 0;
    int          rise_cyc  = 0;
    int          acc_cnt   = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] exp_res[$];
    logic        exp_ovf[$];
    logic [31:0] mon_r;
    logic        mon_o;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout got none expected event", name);
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: sampled mid-low-phase, after stimulus settles and before the next edge
    always @(negedge clk) begin
        #1;
        if (reset_n === 1'b1) begin
            if (bus.din_valid && bus.din_ready) acc_cnt++;
            if (bus.result_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = bus.result_valid;
            if (bus.result_valid && bus.result_ready) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got result %0h expected no result", bus.result);
                end else begin
                    mon_r = exp_res.pop_front();
                    mon_o = exp_ovf.pop_front();
                    check("result", bus.result, mon_r);
                    check("overflow", {31'b0, bus.overflow}, {31'b0, mon_o});
                end
            end
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic start_op(input logic [1:0] m, input logic [31:0] r, input logic o);
        exp_res.push_back(r);
        exp_ovf.push_back(o);
        bus.mode  = m;
        bus.start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = ~m;
    endtask

    task automatic send(input logic [31:0] v, input int gap);
        int t;
        t = 0;
        bus.din       = v;
        bus.din_valid = 1'b1;
        while (bus.din_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout("din_ready");
        @(negedge clk);
        if (gap > 0) begin
            bus.din_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.busy !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) timeout("idle");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"},       bus.result, 32'h0);
        check({tag, "_result_valid"}, {31'b0, bus.result_valid}, 32'h0);
        check({tag, "_din_ready"},    {31'b0, bus.din_ready}, 32'h0);
        check({tag, "_overflow"},     {31'b0, bus.overflow}, 32'h0);
        check({tag, "_busy"},         {31'b0, bus.busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.start        = 1'b0;
        bus.mode         = 2'd0;
        bus.din          = '0;
        bus.din_valid    = 1'b0;
        bus.result_ready = 1'b1;
        reset_n          = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Sum back-to-back, with latency from the start edge
        start_op(2'd0, 32'd26, 1'b0);
        check("busy_after_start", {31'b0, bus.busy}, 32'h1);
        check("din_ready_clear", {31'b0, bus.din_ready}, 32'h0);
        send(32'd5, 0); send(32'd6, 0); send(32'd7, 0); send(32'd8, 0);
        bus.din_valid = 1'b0;
        wait_idle();
        check("sum_latency", rise_cyc - start_cyc, 32'd6);

        // Max with gaps between samples
        acc_cnt = 0;
        start_op(2'd2, 32'd9, 1'b0);
        send(32'd3, 1); send(32'd9, 3); send(32'd2, 2); send(32'd9, 0);
        bus.din_valid = 1'b0;
        wait_idle();
        check("max_accepts", acc_cnt, 32'd4);

        start_op(2'd1, 32'd1, 1'b0);
        send(32'd7, 0); send(32'd1, 0); send(32'd4, 0); send(32'd2, 0);
        bus.din_valid = 1'b0;
        wait_idle();

        start_op(2'd3, 32'd15, 1'b0);
        send(32'd1, 0); send(32'd2, 0); send(32'd4, 0); send(32'd8, 0);
        bus.din_valid = 1'b0;
        wait_idle();

`ifdef ALU_SEQ_ACC_SAT_EN
        start_op(2'd0, 32'hFFFF_FFFF, 1'b1);
`else
        start_op(2'd0, 32'd1, 1'b1);
`endif
        send(32'hFFFF_FFFF, 0); send(32'd2, 0); send(32'd0, 0); send(32'd0, 0);
        bus.din_valid = 1'b0;
        wait_idle();
        check("ovf_hold_idle", {31'b0, bus.overflow}, 32'h1);

        // Overflow must be cleared by the next operation
        start_op(2'd1, 32'd1, 1'b0);
        send(32'd7, 0); send(32'd1, 0); send(32'd4, 0); send(32'd2, 0);
        bus.din_valid = 1'b0;
        wait_idle();

        // Backpressure in DONE with start pulsed
        bus.result_ready = 1'b0;
        start_op(2'd3, 32'd15, 1'b0);
        send(32'd1, 0); send(32'd2, 0); send(32'd4, 0); send(32'd8, 0);
        bus.din_valid = 1'b0;
        t = 0;
        while (bus.result_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout("result_valid");
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'b1;
            check("bp_valid", {31'b0, bus.result_valid}, 32'h1);
            check("bp_result", bus.result, 32'd15);
            @(negedge clk);
        end
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("bp_idle_busy", {31'b0, bus.busy}, 32'h0);
        check("bp_idle_valid", {31'b0, bus.result_valid}, 32'h0);
        @(negedge clk);
        check("bp_start_ignored", {31'b0, bus.busy}, 32'h0);
        check("idle_result_shown", bus.result, 32'd15);

        // Reset in the middle of ACCUM
        start_op(2'd0, 32'd99, 1'b0);
        send(32'd3, 0); send(32'd4, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        void'(exp_res.pop_back());
        void'(exp_ovf.pop_back());
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_op(2'd0, 32'd4, 1'b0);
        send(32'd1, 0); send(32'd1, 0); send(32'd1, 0); send(32'd1, 0);
        bus.din_valid = 1'b0;
        wait_idle();

        repeat (3) @(negedge clk);
        check("queue_empty", exp_res.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_acc.md
ALU_SEQ_ACC -- requirements
Module: alu_seq_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/accumulator width (>=8).
REQ-002 SHALL have parameter NR_INPS, default 4, samples reduced per operation (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-006 SHALL have port mode  input  2  operation: 0 sum, 1 unsigned min, 2 unsigned max, 3 xor; latched on accepted start.
REQ-007 SHALL have port din  input  WIDTH  operand sample.
REQ-008 SHALL have port din_valid  input  1  din holds a valid sample.
REQ-009 SHALL have port din_ready  output  1  block accepts a sample this cycle.
REQ-010 SHALL have port result  output  WIDTH  reduction result.
REQ-011 SHALL have port result_valid  output  1  result is valid.
REQ-012 SHALL have port result_ready  input  1  consumer takes result.
REQ-013 SHALL have port overflow  output  1  sticky sum carry-out flag for the current operation.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, CLEAR, ACCUM, DONE.
REQ-016 IDLE: start=1 -> CLEAR next cycle, mode latched; otherwise stay.
REQ-017 CLEAR (exactly one cycle): accumulator loads 0 (sum, max, xor) or all-ones (min), overflow clears, sample counter clears; -> ACCUM.
REQ-018 ACCUM: din_ready=1; a sample is accepted on a cycle with din_valid=1 and din_ready=1; other cycles leave accumulator and counter unchanged.
REQ-019 Accepted sample: sum acc<=acc+din (WIDTH bits, carry-out sets overflow); min acc<=min(acc,din); max acc<=max(acc,din); xor acc<=acc^din; all comparisons unsigned.
REQ-020 Counter width SHALL be $clog2(NR_INPS+1); on acceptance of sample NR_INPS -> DONE on the same edge.
REQ-021 DONE: result_valid=1, result=acc, held stable until result_ready=1; that cycle -> IDLE.
REQ-022 din_ready SHALL be 0 outside ACCUM; result_valid SHALL be 0 outside DONE.
REQ-023 start outside IDLE SHALL be ignored, including start and result_ready together in DONE (a fresh start in IDLE is required).
REQ-024 mode changes after acceptance SHALL not affect the running operation.
REQ-025 Minimum latency: start at edge t -> result_valid at cycle t+2+NR_INPS with din_valid held high.
REQ-026 overflow SHALL remain 0 in modes 1-3 and hold its value through DONE until the next CLEAR.
REQ-027 result SHALL show the accumulator in every state (0 after reset).

Reset
REQ-028 reset_n=0 SHALL force IDLE immediately, regardless of clk.
REQ-029 In reset: accumulator=0, counter=0, latched mode=0, result=0, result_valid=0, din_ready=0, overflow=0, busy=0.
REQ-030 Reset during ACCUM or DONE SHALL discard the partial operation; the first start after release SHALL run clean.

Configuration
REQ-031 Macro ALU_SEQ_ACC_SAT_EN defined: sum mode saturates at 2^WIDTH-1 on carry-out, overflow still set.
REQ-032 Macro undefined: sum wraps modulo 2^WIDTH; overflow still set; min/max/xor identical in both builds.

Verification (WIDTH=32, NR_INPS=4)
REQ-033 Sum: start mode 0, din 5,6,7,8 back-to-back -> result 26, overflow 0, result_valid 6 cycles after start edge.
REQ-034 Max with gaps: mode 2, din 3,9,2,9 with din_valid low 1-3 cycles between -> result 9, exactly 4 acceptances.
REQ-035 Min: mode 1, din 7,1,4,2 -> result 1; xor: mode 3, din 1,2,4,8 -> result 15.
REQ-036 Overflow: mode 0, din 0xFFFFFFFF,2,0,0 -> no macro: result 1, overflow 1; ALU_SEQ_ACC_SAT_EN: result 0xFFFFFFFF, overflow 1.
REQ-037 Backpressure: result_ready low 5 cycles in DONE with start pulsed -> result_valid and result stable, start ignored, IDLE after result_ready.
REQ-038 Reset mid-ACCUM after 2 samples -> all outputs at reset values asynchronously; next sum 1,1,1,1 -> result 4.
